phase_sequencer: RTL

- Multi-cycle successor to the combinational instruction controller of the SIMPLE 16-bit core.
- Runs a parametrised phase ring of fetch, decode, execute, memory and writeback, with run/stop/halt control from the exec button.
- Latches decoded control at decode; issues write-enable and PC-load strobes only in their owning phase; stalls on memory wait; resolves conditional branches from flags.
- Sits between the datapath registers (IR, PC, register file, data memory) and the top level.

---
 rtl/phase_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - multi-cycle phase ring controller for the SIMPLE 16-bit core
module phase_sequencer #(
    parameter int PHASES  = 5,
    parameter int INSTR_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec,
    input  logic [INSTR_W-1:0] instr,
    input  logic [3:0]         flags,
    input  logic               mem_wait,
    output logic [PHASES-1:0]  phase,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               alu_src,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_we,
    output logic               mem_we,
    output logic               pc_load,
    output logic               running,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       wr;
        logic       st;
        logic       mem;
        logic       hlt;
        logic       br;
        logic       bcc;
        logic [2:0] cond;
    } ctrl_t;

    state_e            state_q, state_d;
    logic [PHASES-1:0] phase_q, phase_d;
    logic              stop_q, stop_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;
    ctrl_t             ctrl_q, ctrl_d;
    ctrl_t             dec;

    logic [15:0] iw;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic [3:0]  op3;
    logic        c_nop, c_ld, c_st, c_li, c_b, c_bcc, c_alu, c_in, c_out, c_hlt;
    logic        stall, taken;
    logic        unused_bits;

    assign iw  = instr[INSTR_W-1 -: 16];
    assign op1 = iw[15:14];
    assign op2 = iw[13:11];
    assign op3 = iw[7:4];

    // An all-zero word is a NOP and belongs to no class, even though op1 reads as LD.
    assign c_nop = (iw == 16'h0000);
    assign c_ld  = (op1 == 2'b00) && !c_nop;
    assign c_st  = (op1 == 2'b01);
    assign c_li  = (op1 == 2'b10) && (op2 == 3'b000);
    assign c_b   = (op1 == 2'b10) && (op2 == 3'b100);
    assign c_bcc = (op1 == 2'b10) && (op2 == 3'b111);
    assign c_alu = (op1 == 2'b11) && (op3 != 4'b0101) && (op3 != 4'b1101) && (op3 != 4'b1111);
    assign c_in  = (op1 == 2'b11) && (op3 == 4'b1100);
    assign c_out = (op1 == 2'b11) && (op3 == 4'b1101);
    assign c_hlt = (op1 == 2'b11) && (op3 == 4'b1111);

    assign unused_bits = ^{instr, flags[1]};

    always_comb begin
        dec            = '0;
        dec.alu_src    = (op3[3:2] == 2'b10);
        dec.reg_dst    = (op1 != 2'b00);
        dec.mem_to_reg = c_ld || c_in;
        dec.wr         = c_ld || c_li || c_alu;
        dec.st         = c_st;
        dec.mem        = c_ld || c_st || c_in || c_out;
        dec.hlt        = c_hlt;
        dec.br         = c_b;
        dec.bcc        = c_bcc;
        dec.cond       = iw[10:8];
    end

    assign stall = mem_wait && (phase_q[0] || (phase_q[PHASES-2] && ctrl_q.mem));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        stop_d  = stop_q;
        ctrl_d  = ctrl_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (exec) begin
                    state_d = ST_RUN;
                    phase_d = PHASES'(1);
                end
            end
            ST_RUN: begin
                if (exec) stop_d = 1'b1;
                if (phase_q[1]) ctrl_d = dec;
                if (!stall) begin
                    if (phase_q[PHASES-1]) begin
                        // A pending stop beats HLT; an exec landing on HLT writeback is dropped.
                        if (stop_q) begin
                            state_d = ST_IDLE;
                            phase_d = '0;
                            stop_d  = 1'b0;
                        end else if (ctrl_q.hlt) begin
                            state_d = ST_HALT;
                            phase_d = '0;
                            stop_d  = 1'b0;
                        end else begin
                            phase_d = PHASES'(1);
                        end
                    end else begin
                        phase_d = phase_q << 1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                stop_d  = 1'b0;
            end
        endcase
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            stop_q    <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            stop_q    <= stop_d;
            running_q <= running_d;
            halted_q  <= halted_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_comb begin
        case (ctrl_q.cond)
            3'b000:  taken = flags[2];
            3'b001:  taken = flags[3] ^ flags[0];
            3'b010:  taken = flags[2] | (flags[3] ^ flags[0]);
            3'b011:  taken = !flags[2];
            default: taken = 1'b0;
        endcase
    end

    assign ir_load    = phase_q[0] && !mem_wait;
    assign pc_inc     = ir_load;
    assign mem_we     = phase_q[PHASES-2] && ctrl_q.st && !mem_wait;
    assign reg_we     = phase_q[PHASES-1] && ctrl_q.wr;
    assign pc_load    = phase_q[PHASES-1] && (ctrl_q.br || (ctrl_q.bcc && taken));
    assign alu_src    = ctrl_q.alu_src;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign phase      = phase_q;
    assign running    = running_q;
    assign halted     = halted_q;

endmodule
